// File: rtl/spi_slave_sync_if.sv
// System-side and pin-side signals of the oversampled SPI slave, bundled for port lists.
interface spi_slave_sync_if #(
    parameter int DATA_W = 8
);
    logic              spi_sclk;
    logic              spi_cs;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport slave (
        input  spi_sclk, spi_cs, spi_mosi, tx_data, tx_valid, rx_ready,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid
    );

    modport master (
        output spi_sclk, spi_cs, spi_mosi, tx_data, tx_valid, rx_ready,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI slave fully clocked by clk: pins are oversampled, edges detected, all CPOL/CPHA modes.
// Define SPI_SLAVE_SYNC_STATUS_EN to add sticky overrun/underrun flags with a clear input.
module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_sync_if.slave  bus,
    output logic             busy
`ifdef SPI_SLAVE_SYNC_STATUS_EN
    ,
    output logic             ovr_flag,
    output logic             udr_flag,
    input  logic             status_clr
`endif
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(DATA_W - 1);
    localparam logic              IDLE_LVL = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_dly, cs_dly;
    logic [SYNC_STAGES:0]   sync_vld_p0;
    logic                   armed;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   lead, trail, cs_fall, cs_rise;
    logic                   frame_start, sample, shift;
    logic                   word_done, load, tx_wr, rx_take;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shift_in, shift_in_nxt, shift_out, tx_buf, rx_word;
    logic                   out_bit, tx_full, rx_vld;

    // Synchroniser stage; armed stays low until a real high cs has been seen after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            sclk_dly    <= 1'b0;
            cs_dly      <= 1'b1;
            sync_vld_p0 <= '0;
            armed       <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_dly    <= sclk_s;
            cs_dly      <= cs_s;
            sync_vld_p0 <= {sync_vld_p0[SYNC_STAGES-1:0], 1'b1};
            if (sync_vld_p0[SYNC_STAGES] && cs_s && cs_dly)
                armed <= 1'b1;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign lead    = (sclk_dly == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail   = (sclk_dly != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign cs_fall = armed && cs_dly && !cs_s;
    assign cs_rise = !cs_dly && cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        sample      = 1'b0;
        shift       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    sample = (CPHA != 0) ? trail : lead;
                    shift  = (CPHA != 0) ? lead  : trail;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_in_nxt = {shift_in[DATA_W-2:0], mosi_s};
    assign word_done    = sample && (bit_cnt == '0);
    assign load         = frame_start || word_done;
    assign tx_wr        = bus.tx_valid && !tx_full;
    assign rx_take      = word_done && (!rx_vld || bus.rx_ready);

    // Shift/receive stage; in CPHA=0 the trailing edge right after a reload must not shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= LAST;
            shift_in  <= '0;
            shift_out <= '0;
            out_bit   <= 1'b0;
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            rx_word   <= '0;
            rx_vld    <= 1'b0;
        end else begin
            if (frame_start)
                bit_cnt <= LAST;
            else if (sample)
                bit_cnt <= word_done ? LAST : bit_cnt - 1'b1;

            if (sample)
                shift_in <= shift_in_nxt;

            if (frame_start)
                out_bit <= 1'b0;

            if (load) begin
                shift_out <= tx_full ? tx_buf : '0;
            end else if (shift && ((CPHA != 0) || (bit_cnt != LAST))) begin
                shift_out <= shift_out << 1;
                out_bit   <= shift_out[DATA_W-1];
            end

            if (tx_wr) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end

            if (rx_take) begin
                rx_word <= shift_in_nxt;
                rx_vld  <= 1'b1;
            end else if (rx_vld && bus.rx_ready) begin
                rx_vld <= 1'b0;
            end
        end
    end

    assign bus.spi_miso    = (state_q == ACTIVE) && ((CPHA != 0) ? out_bit : shift_out[DATA_W-1]);
    assign bus.spi_miso_oe = (state_q == ACTIVE);
    assign busy            = (state_q == ACTIVE);
    assign bus.tx_ready    = !tx_full;
    assign bus.rx_data     = rx_word;
    assign bus.rx_valid    = rx_vld;

`ifdef SPI_SLAVE_SYNC_STATUS_EN
    logic overrun, underrun;

    assign overrun  = word_done && rx_vld && !bus.rx_ready;
    assign underrun = load && !tx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_flag <= 1'b0;
            udr_flag <= 1'b0;
        end else begin
            if (overrun)         ovr_flag <= 1'b1;
            else if (status_clr) ovr_flag <= 1'b0;
            if (underrun)        udr_flag <= 1'b1;
            else if (status_clr) udr_flag <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// Drives four spi_slave_sync instances (modes 0..3) with identical frames and scoreboards them.
module tb_spi_slave_sync;
    localparam int HP = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_raw = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi_a = 1'b0;
    logic       mosi_b = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       status_clr = 1'b0;

    logic [3:0] miso, oe, tx_ready, rx_valid, busy, ovr, udr;
    logic [7:0] rx_data [4];
    logic [7:0] got [4];

    logic [7:0] miso_q [$];
    logic [7:0] rx_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : mode
        localparam logic POL = (g / 2) != 0;
        localparam logic PHA = (g % 2) != 0;
        spi_slave_sync_if #(.DATA_W(8)) bus ();

        assign bus.spi_sclk = sclk_raw ^ POL;
        assign bus.spi_cs   = cs_n;
        assign bus.spi_mosi = PHA ? mosi_b : mosi_a;
        assign bus.tx_data  = tx_data;
        assign bus.tx_valid = tx_valid;
        assign bus.rx_ready = rx_ready;
        assign miso[g]      = bus.spi_miso;
        assign oe[g]        = bus.spi_miso_oe;
        assign tx_ready[g]  = bus.tx_ready;
        assign rx_valid[g]  = bus.rx_valid;
        assign rx_data[g]   = bus.rx_data;

        spi_slave_sync #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .busy       (busy[g])
`ifdef SPI_SLAVE_SYNC_STATUS_EN
            ,
            .ovr_flag   (ovr[g]),
            .udr_flag   (udr[g]),
            .status_clr (status_clr)
`endif
        );
`ifndef SPI_SLAVE_SYNC_STATUS_EN
        assign ovr[g] = 1'b0;
        assign udr[g] = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'h0);
        check({tag, "_oe"}, 32'(oe), 32'h0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'hF);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        for (int g = 0; g < 4; g++)
            check($sformatf("%s_rx_data_m%0d", tag, g), 32'(rx_data[g]), 32'h0);
    endtask

    task automatic tx_write(input logic [7:0] d, input bit push);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (push) miso_q.push_back(d);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #(2 * HP);
    endtask

    task automatic cs_high();
        #(HP);
        cs_n = 1'b1;
        #(2 * HP);
    endtask

    task automatic spi_word(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi_a = w[7-i];
            #(HP);
            for (int g = 0; g < 4; g += 2) got[g][7-i] = miso[g];
            sclk_raw = 1'b1;
            mosi_b   = w[7-i];
            #(HP);
            for (int g = 1; g < 4; g += 2) got[g][7-i] = miso[g];
            sclk_raw = 1'b0;
        end
    endtask

    task automatic check_miso();
        logic [7:0] exp;
        exp = miso_q.pop_front();
        for (int g = 0; g < 4; g++)
            check($sformatf("master_read_m%0d", g), 32'(got[g]), 32'(exp));
    endtask

    task automatic wait_rx();
        int n;
        logic [7:0] exp;
        n = 0;
        while (rx_valid != 4'hF && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_rise", 32'(rx_valid), 32'hF);
        exp = rx_q.pop_front();
        for (int g = 0; g < 4; g++)
            check($sformatf("rx_data_m%0d", g), 32'(rx_data[g]), 32'(exp));
    endtask

    task automatic rx_handshake();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_valid_clear", 32'(rx_valid), 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Mode sweep with 0x3C/0xA5, rx_valid must hold without rx_ready
        tx_write(8'h3C, 1'b1);
        check("tx_ready_full", 32'(tx_ready), 32'h0);
        cs_low();
        check("busy_frame", 32'(busy), 32'hF);
        check("oe_frame", 32'(oe), 32'hF);
        check("tx_ready_after_load", 32'(tx_ready), 32'hF);
        rx_q.push_back(8'hA5);
        spi_word(8'hA5, 8);
        check_miso();
        wait_rx();
        repeat (5) @(negedge clk);
        check("rx_valid_held", 32'(rx_valid), 32'hF);
        rx_handshake();
        cs_high();
        check("busy_idle", 32'(busy), 32'h0);
        check("oe_idle", 32'(oe), 32'h0);
        check("miso_idle", 32'(miso), 32'h0);

        // 0x81 out, 0x7E in
        tx_write(8'h81, 1'b1);
        cs_low();
        rx_q.push_back(8'h7E);
        spi_word(8'h7E, 8);
        check_miso();
        wait_rx();
        rx_handshake();
        cs_high();

        // Two words in one chip-select with a refill between loads
        tx_write(8'hAA, 1'b1);
        cs_low();
        tx_write(8'hBB, 1'b1);
        rx_q.push_back(8'h11);
        spi_word(8'h11, 8);
        check_miso();
        wait_rx();
        rx_handshake();
        rx_q.push_back(8'h22);
        spi_word(8'h22, 8);
        check_miso();
        wait_rx();
        rx_handshake();
        cs_high();

        // Partial word is discarded, next frame is clean
        tx_write(8'h5A, 1'b0);
        cs_low();
        spi_word(8'hFF, 5);
        cs_high();
        repeat (10) @(negedge clk);
        check("partial_no_rx", 32'(rx_valid), 32'h0);
        tx_write(8'h96, 1'b1);
        cs_low();
        rx_q.push_back(8'hC3);
        spi_word(8'hC3, 8);
        check_miso();
        wait_rx();
        rx_handshake();
        cs_high();

        // Underrun and overrun
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        check("udr_cleared", 32'(udr), 32'h0);
        check("ovr_cleared", 32'(ovr), 32'h0);
`endif
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h00);
        cs_low();
        rx_q.push_back(8'h01);
        spi_word(8'h01, 8);
        check_miso();
        spi_word(8'h02, 8);
        check_miso();
        repeat (8) @(negedge clk);
        wait_rx();
`ifdef SPI_SLAVE_SYNC_STATUS_EN
        check("udr_set", 32'(udr), 32'hF);
        check("ovr_set", 32'(ovr), 32'hF);
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        check("udr_clr", 32'(udr), 32'h0);
        check("ovr_clr", 32'(ovr), 32'h0);
`endif
        rx_handshake();
        cs_high();

        // Reset mid-word; the still-low cs must be ignored
        tx_write(8'h44, 1'b0);
        cs_low();
        spi_word(8'hF0, 4);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_busy_low", 32'(busy), 32'h0);
        spi_word(8'hE7, 8);
        repeat (10) @(negedge clk);
        check("midrst_no_rx", 32'(rx_valid), 32'h0);
        check("midrst_oe_low", 32'(oe), 32'h0);
        cs_high();
        tx_write(8'h69, 1'b1);
        cs_low();
        rx_q.push_back(8'h3D);
        spi_word(8'h3D, 8);
        check_miso();
        wait_rx();
        rx_handshake();
        cs_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
